// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and frame constants for the ADC sample sequencer
package adc_pkg;

  // Frame sequencer states; anything other than IDLE counts as busy.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } adc_state_t;

  // 16-SCLK frame: 4 leading zeros followed by 12 data bits, MSB first.
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;
  localparam int ADC_LEAD_ZEROS = 4;

endpackage

// File: rtl/adc_period_tick.sv
// rtl/adc_period_tick.sv - enabled free-running period counter producing a one-cycle tick
module adc_period_tick #(
  parameter int PERIOD = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == COUNT_LAST);

  // Count 0..PERIOD-1 while enabled, wrap to 0; held at 0 while disabled.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_count <= '0;
    end else if (w_at_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = i_enable && w_at_last;

endmodule

// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - periodic CS/SCLK framed serial ADC conversion controller
module adc_sample_sequencer
  import adc_pkg::*;
#(
  parameter int SCLK_HALF     = 25,
  parameter int SAMPLE_PERIOD = 100000,
  parameter int QUIET_CYCLES  = 5
) (
  input  logic        Clck_in,
  input  logic        reset_Clock,
  input  logic        enable,
  input  logic        adc_sdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int HW = $clog2(SCLK_HALF);
  localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam int BW = $clog2(ADC_FRAME_BITS + 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(SCLK_HALF - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [BW-1:0] BITS_LAST  = BW'(ADC_LEAD_ZEROS + ADC_DATA_BITS);

  logic                     w_tick;
  adc_state_t               r_state;
  logic [HW-1:0]            r_hcnt;
  logic [QW-1:0]            r_qcnt;
  logic [BW-1:0]            r_bcnt;
  logic [ADC_DATA_BITS-1:0] r_shift;
  logic                     r_cs_n;
  logic                     r_sclk;
  logic [ADC_DATA_BITS-1:0] r_sample;
  logic                     r_valid;
  logic                     r_busy;
  logic                     r_overrun;

  adc_period_tick #(
    .PERIOD (SAMPLE_PERIOD)
  ) u_period_tick (
    .i_clk    (Clck_in),
    .i_rst    (reset_Clock),
    .i_enable (enable),
    .o_tick   (w_tick)
  );

  // Frame sequencer: LEAD half-period, 32 SCLK half-periods, then QUIET with CS high.
  // The shift register is only data-width wide, so the leading zeros fall out the top.
  always_ff @(posedge Clck_in) begin
    if (reset_Clock) begin
      r_state   <= IDLE;
      r_hcnt    <= '0;
      r_qcnt    <= '0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b1;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= w_tick && r_busy;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state <= LEAD;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
          end
        end
        LEAD: begin
          if (r_hcnt == HALF_LAST) begin
            r_hcnt  <= '0;
            r_sclk  <= 1'b0;
            r_state <= SHIFT;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        SHIFT: begin
          if (r_hcnt == HALF_LAST) begin
            r_hcnt <= '0;
            if (r_sclk && (r_bcnt == BITS_LAST)) begin
              // Last high half-period done: close the frame.
              r_cs_n   <= 1'b1;
              r_sample <= r_shift;
              r_valid  <= 1'b1;
              r_qcnt   <= '0;
              r_state  <= QUIET;
            end else begin
              r_sclk <= ~r_sclk;
              if (!r_sclk) begin
                r_shift <= {r_shift[ADC_DATA_BITS-2:0], adc_sdata};
                r_bcnt  <= r_bcnt + 1'b1;
              end
            end
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        QUIET: begin
          if (r_qcnt == QUIET_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_qcnt <= r_qcnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign adc_cs_n     = r_cs_n;
  assign adc_sclk     = r_sclk;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb/tb_adc_sample_sequencer.sv - directed self-checking bench for adc_sample_sequencer
module tb_adc_sample_sequencer;

  localparam int SH     = 4;
  localparam int SP     = 200;
  localparam int QC     = 5;
  localparam int SP_OVR = 100;
  localparam int CS_LOW = 33 * SH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        adc_sdata = 1'b0;
  logic        adc_cs_n, adc_sclk, sample_valid, busy, overrun;
  logic [11:0] sample;

  // Short-period instance for overrun
  logic        rst2 = 1'b1;
  logic        en2 = 1'b0;
  logic        adc_sdata2 = 1'b0;
  logic        adc_cs_n2, adc_sclk2, sample_valid2, busy2, overrun2;
  logic [11:0] sample2;

  adc_sample_sequencer #(.SCLK_HALF(SH), .SAMPLE_PERIOD(SP), .QUIET_CYCLES(QC)) u_dut (
    .Clck_in(clk), .reset_Clock(rst), .enable(en), .adc_sdata(adc_sdata),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample(sample),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  adc_sample_sequencer #(.SCLK_HALF(SH), .SAMPLE_PERIOD(SP_OVR), .QUIET_CYCLES(QC)) u_dut_ovr (
    .Clck_in(clk), .reset_Clock(rst2), .enable(en2), .adc_sdata(adc_sdata2),
    .adc_cs_n(adc_cs_n2), .adc_sclk(adc_sclk2), .sample(sample2),
    .sample_valid(sample_valid2), .busy(busy2), .overrun(overrun2)
  );

  // ADC models: latch the word at CS fall, present the next bit on each SCLK fall.
  logic [15:0] adc_word = 16'h0000;
  logic [15:0] adc_shreg = 16'h0000;
  always @(negedge adc_sclk or negedge adc_cs_n) begin
    if (adc_sclk === 1'b1) adc_shreg = adc_word;
    else if (adc_cs_n === 1'b0) begin
      adc_sdata = adc_shreg[15];
      adc_shreg = {adc_shreg[14:0], 1'b0};
    end
  end

  logic [15:0] adc_word2 = 16'h0000;
  logic [15:0] adc_shreg2 = 16'h0000;
  always @(negedge adc_sclk2 or negedge adc_cs_n2) begin
    if (adc_sclk2 === 1'b1) adc_shreg2 = adc_word2;
    else if (adc_cs_n2 === 1'b0) begin
      adc_sdata2 = adc_shreg2[15];
      adc_shreg2 = {adc_shreg2[14:0], 1'b0};
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int prev_fall = 0;

  task automatic wait_cs_fall(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      if (adc_cs_n === 1'b0) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Evaluates the current cycle and span-1 following ones; leaves time at the next unevaluated cycle.
  task automatic capture_frame(input int span, output int low, output int rises,
                               output int vcyc, output int vcnt);
    logic prev;
    low = 0; rises = 0; vcyc = -1; vcnt = 0; prev = adc_sclk;
    for (int i = 0; i < span; i++) begin
      if (adc_cs_n === 1'b0) begin
        low++;
        if (prev === 1'b0 && adc_sclk === 1'b1) rises++;
      end
      prev = adc_sclk;
      if (sample_valid === 1'b1) begin
        vcnt++;
        if (vcyc < 0) vcyc = cyc;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", adc_cs_n); end
    n_tests++; if (adc_sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b want 1", adc_sclk); end
    n_tests++; if (sample !== 12'h000) begin n_fail++; $display("FAIL reset_sample: got %h want 000", sample); end
    n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int t, low, rises, vcyc, vcnt;
    adc_word = 16'h0A5C;
    en = 1'b1;
    wait_cs_fall(2 * SP, t);
    n_tests++; if (t < 0) begin n_fail++; $display("FAIL single_start: no cs_n fall within %0d cycles", 2 * SP); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    capture_frame(SP - 5, low, rises, vcyc, vcnt);
    n_tests++; if (sample !== 12'hA5C) begin n_fail++; $display("FAIL single_sample: got %h want a5c", sample); end
    n_tests++; if (low != CS_LOW) begin n_fail++; $display("FAIL single_cs_low: got %0d want %0d", low, CS_LOW); end
    n_tests++; if (rises != 16) begin n_fail++; $display("FAIL single_rises: got %0d want 16", rises); end
    n_tests++; if (vcnt != 1) begin n_fail++; $display("FAIL single_valid_count: got %0d want 1", vcnt); end
    n_tests++; if (vcyc - t != CS_LOW) begin n_fail++; $display("FAIL single_valid_latency: got %0d want %0d", vcyc - t, CS_LOW); end
    n_tests++; if (adc_sclk !== 1'b1) begin n_fail++; $display("FAIL single_sclk_idle: got %b want 1", adc_sclk); end
    prev_fall = t;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic [11:0] exp   [3];
    int t, low, rises, vcyc, vcnt;
    words[0] = 16'h0000; exp[0] = 12'h000;
    words[1] = 16'h0FFF; exp[1] = 12'hFFF;
    words[2] = 16'h0800; exp[2] = 12'h800;
    for (int k = 0; k < 3; k++) begin
      adc_word = words[k];
      wait_cs_fall(50, t);
      n_tests++; if (t - prev_fall != SP) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, t - prev_fall, SP); end
      capture_frame(SP - 5, low, rises, vcyc, vcnt);
      n_tests++; if (sample !== exp[k]) begin n_fail++; $display("FAIL b2b_sample[%0d]: got %h want %h", k, sample, exp[k]); end
      n_tests++; if (vcnt != 1) begin n_fail++; $display("FAIL b2b_valid_count[%0d]: got %0d want 1", k, vcnt); end
      prev_fall = t;
    end
  endtask

  task automatic test_enable_drop();
    int t, low1, r1, v1, c1, low2, r2, v2, c2;
    adc_word = 16'h0F0F;
    wait_cs_fall(50, t);
    n_tests++; if (t < 0) begin n_fail++; $display("FAIL drop_start: no cs_n fall within 50 cycles"); end
    capture_frame(60, low1, r1, v1, c1);
    en = 1'b0;
    capture_frame(140, low2, r2, v2, c2);
    n_tests++; if (low1 + low2 != CS_LOW) begin n_fail++; $display("FAIL drop_cs_low: got %0d want %0d", low1 + low2, CS_LOW); end
    n_tests++; if (c1 + c2 != 1) begin n_fail++; $display("FAIL drop_valid_count: got %0d want 1", c1 + c2); end
    n_tests++; if (v2 - t != CS_LOW) begin n_fail++; $display("FAIL drop_valid_latency: got %0d want %0d", v2 - t, CS_LOW); end
    n_tests++; if (sample !== 12'hF0F) begin n_fail++; $display("FAIL drop_sample: got %h want f0f", sample); end
    capture_frame(3 * SP, low1, r1, v1, c1);
    n_tests++; if (low1 != 0) begin n_fail++; $display("FAIL drop_quiet_cs: got %0d low cycles want 0", low1); end
    n_tests++; if (c1 != 0) begin n_fail++; $display("FAIL drop_quiet_valid: got %0d valids want 0", c1); end
  endtask

  task automatic test_reset_mid_frame();
    int t, low, rises, vcyc, vcnt;
    adc_word = 16'h0321;
    en = 1'b1;
    wait_cs_fall(2 * SP, t);
    n_tests++; if (t < 0) begin n_fail++; $display("FAIL rstmid_start: no cs_n fall within %0d cycles", 2 * SP); end
    capture_frame(40, low, rises, vcyc, vcnt);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    n_tests++; if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs_n: got %b want 1", adc_cs_n); end
    n_tests++; if (sample !== 12'h000) begin n_fail++; $display("FAIL rstmid_sample: got %h want 000", sample); end
    n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", sample_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    capture_frame(5, low, rises, vcyc, vcnt);
    n_tests++; if (vcnt != 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d want 0", vcnt); end
    en = 1'b1;
    wait_cs_fall(2 * SP, t);
    n_tests++; if (t < 0) begin n_fail++; $display("FAIL rstmid_restart: no cs_n fall within %0d cycles", 2 * SP); end
    capture_frame(SP - 5, low, rises, vcyc, vcnt);
    n_tests++; if (sample !== 12'h321) begin n_fail++; $display("FAIL rstmid_next_sample: got %h want 321", sample); end
    n_tests++; if (vcyc - t != CS_LOW) begin n_fail++; $display("FAIL rstmid_next_latency: got %0d want %0d", vcyc - t, CS_LOW); end
    en = 1'b0;
  endtask

  task automatic test_overrun();
    int t1, t2, n_ovr, n_ovr_busy, n_falls, n_valid;
    logic prev_cs;
    adc_word2 = 16'h0123;
    en2 = 1'b1;
    t1 = -1;
    for (int i = 0; i < 3 * SP_OVR; i++) begin
      if (adc_cs_n2 === 1'b0) begin t1 = cyc; break; end
      @(negedge clk);
    end
    n_tests++; if (t1 < 0) begin n_fail++; $display("FAIL ovr_start: no cs_n fall within %0d cycles", 3 * SP_OVR); end
    n_ovr = 0; n_ovr_busy = 0; n_falls = 0; n_valid = 0; prev_cs = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (overrun2 === 1'b1) begin
        n_ovr++;
        if (busy2 === 1'b1) n_ovr_busy++;
      end
      if (prev_cs === 1'b1 && adc_cs_n2 === 1'b0) n_falls++;
      if (sample_valid2 === 1'b1) n_valid++;
      prev_cs = adc_cs_n2;
      @(negedge clk);
    end
    n_tests++; if (n_ovr != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr); end
    n_tests++; if (n_ovr_busy != 1) begin n_fail++; $display("FAIL ovr_while_busy: got %0d want 1", n_ovr_busy); end
    n_tests++; if (n_falls != 0) begin n_fail++; $display("FAIL ovr_extra_cs_fall: got %0d want 0", n_falls); end
    n_tests++; if (n_valid != 1) begin n_fail++; $display("FAIL ovr_valid_count: got %0d want 1", n_valid); end
    n_tests++; if (sample2 !== 12'h123) begin n_fail++; $display("FAIL ovr_sample: got %h want 123", sample2); end
    t2 = -1;
    for (int i = 0; i < SP_OVR; i++) begin
      if (adc_cs_n2 === 1'b0) begin t2 = cyc; break; end
      @(negedge clk);
    end
    n_tests++; if (t2 - t1 != 2 * SP_OVR) begin n_fail++; $display("FAIL ovr_next_frame: got spacing %0d want %0d", t2 - t1, 2 * SP_OVR); end
    en2 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst2 = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
